// File: rtl/turfio_aurora_reset_seq.sv
// turfio_aurora_reset_seq
// Per-channel Aurora reset sequencer. Each channel runs an independent FSM:
//   GT_RST (hold gt+system reset) -> SYS_RST (hold system reset) ->
//   WAIT_UP (wait for synchronised channel_up) -> RUN, with a timeout that
//   either retries the whole sequence or parks the channel in FAIL.
// A debounced per-channel request restarts the sequence from any state.
//
// Ports:
//   init_clk_i      sole clock, rising edge
//   reset_i         synchronous active-high reset
//   gt_reset_req_i  [NCHAN]    per-channel reset request (init_clk_i domain)
//   channel_up_i    [NCHAN]    per-channel Aurora channel_up (asynchronous)
//   gt_reset_o      [NCHAN]    per-channel GT reset, active-high
//   system_reset_o  [NCHAN]    per-channel Aurora system reset, active-high
//   ready_o         [NCHAN]    per-channel link ready
//   err_count_o     [8*NCHAN]  per-channel saturating error count, ch n at [8n+7:8n]
//
// All registers take their idle values (GT_RST, resets asserted, counters
// zero) from reset_i.
module turfio_aurora_reset_seq #(
  parameter int unsigned NCHAN    = 4,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned GT_HOLD  = 128,
  parameter int unsigned SYS_HOLD = 64,
  parameter int unsigned TIMEOUT  = 1048576,
  parameter int unsigned RETRY_EN = 1
) (
  input  logic               init_clk_i,
  input  logic               reset_i,
  input  logic [NCHAN-1:0]   gt_reset_req_i,
  input  logic [NCHAN-1:0]   channel_up_i,
  output logic [NCHAN-1:0]   gt_reset_o,
  output logic [NCHAN-1:0]   system_reset_o,
  output logic [NCHAN-1:0]   ready_o,
  output logic [8*NCHAN-1:0] err_count_o
);

  localparam int unsigned HOLD_MAX = (GT_HOLD > SYS_HOLD) ? GT_HOLD : SYS_HOLD;
  localparam int unsigned CNT_MAX  = (HOLD_MAX > TIMEOUT) ? HOLD_MAX : TIMEOUT;
  localparam int unsigned CW       = $clog2(CNT_MAX) + 1;
  localparam int unsigned DW       = $clog2(DEBOUNCE) + 1;

  localparam logic [CW-1:0] GT_LAST  = CW'(GT_HOLD - 1);
  localparam logic [CW-1:0] SYS_LAST = CW'(SYS_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    GT_RST,
    SYS_RST,
    WAIT_UP,
    RUN,
    FAIL
  } state_t;

  for (genvar ch = 0; ch < NCHAN; ch = ch + 1) begin : g_chan
    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] deb_cnt;
    (* ASYNC_REG = "TRUE" *) logic up_meta;
    (* ASYNC_REG = "TRUE" *) logic up_sync;
    logic          gt_rst_q;
    logic          sys_rst_q;
    logic          ready_q;
    logic [7:0]    err_q;
    logic          req_fire;
    logic          timeout_hit;
    logic          link_drop;

    // Debounce counter saturates one short of the window, so a request held
    // high keeps firing every cycle and pins the channel in GT_RST.
    assign req_fire    = gt_reset_req_i[ch] && (deb_cnt == DEB_LAST);
    assign timeout_hit = (state == WAIT_UP) && !up_sync && (cnt == TO_LAST);
    assign link_drop   = (state == RUN) && !up_sync;

    always_ff @(posedge init_clk_i) begin
      if (reset_i) begin
        state     <= GT_RST;
        cnt       <= '0;
        deb_cnt   <= '0;
        up_meta   <= 1'b0;
        up_sync   <= 1'b0;
        gt_rst_q  <= 1'b1;
        sys_rst_q <= 1'b1;
        ready_q   <= 1'b0;
        err_q     <= '0;
      end else begin
        up_meta <= channel_up_i[ch];
        up_sync <= up_meta;

        if (!gt_reset_req_i[ch])
          deb_cnt <= '0;
        else if (deb_cnt != DEB_LAST)
          deb_cnt <= deb_cnt + DW'(1);

        // Faults are counted even when a request overrides the transition.
        if ((timeout_hit || link_drop) && (err_q != 8'hFF))
          err_q <= err_q + 8'd1;

        if (req_fire) begin
          state     <= GT_RST;
          cnt       <= '0;
          gt_rst_q  <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end else begin
          case (state)
            GT_RST: begin
              if (cnt == GT_LAST) begin
                state    <= SYS_RST;
                cnt      <= '0;
                gt_rst_q <= 1'b0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            SYS_RST: begin
              if (cnt == SYS_LAST) begin
                state     <= WAIT_UP;
                cnt       <= '0;
                sys_rst_q <= 1'b0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            WAIT_UP: begin
              if (up_sync) begin
                state   <= RUN;
                cnt     <= '0;
                ready_q <= 1'b1;
              end else if (timeout_hit) begin
                cnt       <= '0;
                sys_rst_q <= 1'b1;
                if (RETRY_EN != 0) begin
                  state    <= GT_RST;
                  gt_rst_q <= 1'b1;
                end else begin
                  state <= FAIL;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            RUN: begin
              if (link_drop) begin
                state     <= GT_RST;
                cnt       <= '0;
                gt_rst_q  <= 1'b1;
                sys_rst_q <= 1'b1;
                ready_q   <= 1'b0;
              end
            end
            FAIL: begin
              // Parked; only a debounced request or reset_i leaves.
            end
            default: begin
              state     <= GT_RST;
              cnt       <= '0;
              gt_rst_q  <= 1'b1;
              sys_rst_q <= 1'b1;
              ready_q   <= 1'b0;
            end
          endcase
        end
      end
    end

    assign gt_reset_o[ch]          = gt_rst_q;
    assign system_reset_o[ch]      = sys_rst_q;
    assign ready_o[ch]             = ready_q;
    assign err_count_o[8*ch +: 8]  = err_q;
  end

endmodule
